led_worm_sequencer: RTL and testbench
=====================================

// Module: led_worm_sequencer
// PURPOSE
//   Scheduler for the LED-worm display. Divides inClk by a run-time selectable ratio into a
//   one-cycle step tick, and on each tick moves a WORM_LEN-wide block of lit LEDs one position.
//   Provides start/pause/stop sequencing.
//   Sits between the board clock and the LED outputs. Replaces free-running divided clocks with
//   a single clock domain plus a clock enable.
// PARAMETERS
//   NUM_LEDS  8           width of LED bank; must satisfy NUM_LEDS > WORM_LEN
//   WORM_LEN  3           number of adjacent lit LEDs; >= 1
//   DIV_W     24          width of prescale counter
//   BASE_DIV  12_500_000  cycles per step at speedSel=0; BASE_DIV>>3 must be >= 1
// PORTS
//   inClk     in   1         sole clock, rising edge
//   reset     in   1         synchronous, active-high reset
//   start     in   1         one-cycle request: IDLE->RUN (load worm) or PAUSE->RUN (resume)
//   stop      in   1         one-cycle request: RUN->PAUSE or PAUSE->IDLE
//   dirIn     in   1         initial direction, sampled on start from IDLE (0 = toward MSB)
//   speedSel  in   2         step period = BASE_DIV >> speedSel cycles
//   leds      out  NUM_LEDS  LED drive, registered
//   stepTick  out  1         one-cycle pulse on each worm step
//   dirOut    out  1         current direction (0 = toward MSB)
//   busy      out  1         high when state != IDLE
// BEHAVIOUR
//   - Reset (sync, takes priority over everything):
//     state=IDLE, leds=0, counter=0, stepTick=0, dirOut=0, busy=0. Asserting reset mid-RUN or
//     mid-PAUSE gives these values after the next edge.
//   - Terminal count: T = (BASE_DIV >> speedSel) - 1, recomputed every cycle.
//   - States:
//     IDLE : leds=0. On start, go to RUN and clear the counter. Loaded worm (visible next cycle):
//            dirIn=0 -> bits [WORM_LEN-1:0]; dirIn=1 -> bits [NUM_LEDS-1:NUM_LEDS-WORM_LEN].
//            dirOut<=dirIn.
//     RUN  : counter += 1 each cycle. When counter >= T: counter<=0, stepTick<=1, worm moves one
//            position. Using >= means a speedSel change that drops T below the current count
//            ticks on the next cycle.
//            On stop, go to PAUSE; no tick is issued that cycle.
//     PAUSE: leds and counter hold; stepTick=0. start -> RUN, resuming from the held count.
//            stop -> IDLE.
//   - Priority: start and stop in the same cycle -> stop wins; start in RUN ignored;
//     stop in IDLE ignored.
//   - First step occurs T+1 cycles after entering RUN. stepTick and the leds update happen on
//     the same edge.
//   - End handling without the macro (bounce): if the worm touches the end in the current
//     direction (leds[NUM_LEDS-1]=1 with dirOut=0, or leds[0]=1 with dirOut=1), the next tick
//     flips dirOut and shifts one position the opposite way. Lit LEDs never leave the bank and
//     popcount(leds) stays WORM_LEN.
// CONFIGURATION
//   LED_WORM_WRAP_EN defined:
//     - Moves are rotations: the bit leaving one end enters at the other end.
//     - dirOut changes only on start from IDLE (sampled from dirIn).
//   Undefined: bounce behaviour as above. No ports differ between the two builds.
// TESTING   (bench: BASE_DIV=8, NUM_LEDS=8, WORM_LEN=3)
//   1. reset; start, dirIn=0, speedSel=0 -> next cycle leds=00000111, busy=1; stepTick after
//      8 cycles; leds=00001110.
//   2. Continue -> after tick 5 leds=11100000; tick 6 gives leds=01110000, dirOut=1
//      (macro off).
//   3. Macro on, same run -> tick 6 gives leds=11000001, dirOut=0.
//   4. speedSel=3 -> stepTick every cycle. Switch to speedSel=0 at count 5 -> next tick 3
//      cycles later. Switch 0->2 at count 5 -> tick next cycle.
//   5. stop in RUN at count 4 -> leds held and no stepTick for 20 cycles; start -> tick 4
//      cycles later. stop twice -> leds=0, busy=0.
//   6. start+stop together in IDLE -> stays IDLE. reset mid-RUN -> all outputs zero next cycle.

Source files
------------

// File: rtl/led_worm_sequencer.sv
// LED-worm scheduler: divides inClk into a one-cycle step tick and moves a WORM_LEN-wide lit block.
// Optional build macro LED_WORM_WRAP_EN: moves rotate around the bank instead of bouncing at the ends.
module led_worm_sequencer #(
    parameter int NUM_LEDS = 8,
    parameter int WORM_LEN = 3,
    parameter int DIV_W    = 24,
    parameter int BASE_DIV = 12_500_000
) (
    input  logic                inClk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                dirIn,
    input  logic [1:0]          speedSel,
    output logic [NUM_LEDS-1:0] leds,
    output logic                stepTick,
    output logic                dirOut,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} stateT;

    localparam logic [NUM_LEDS-1:0] LOW_WORM  = NUM_LEDS'((1 << WORM_LEN) - 1);
    localparam logic [NUM_LEDS-1:0] HIGH_WORM = LOW_WORM << (NUM_LEDS - WORM_LEN);
    localparam logic [DIV_W-1:0]    BASE_CNT  = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0]    ONE_CNT   = DIV_W'(1);

    stateT               stateReg, stateNext;
    logic [NUM_LEDS-1:0] ledsReg, ledsNext, movedLeds;
    logic [DIV_W-1:0]    countReg, countNext, termCount;
    logic                tickReg, tickNext;
    logic                dirReg, dirNext, movedDir;

    // Terminal count follows speedSel every cycle so a rate change takes effect immediately.
    assign termCount = (BASE_CNT >> speedSel) - ONE_CNT;

    always_comb begin
        movedLeds = ledsReg;
        movedDir  = dirReg;
`ifdef LED_WORM_WRAP_EN
        if (!dirReg) begin
            movedLeds = {ledsReg[NUM_LEDS-2:0], ledsReg[NUM_LEDS-1]};
        end else begin
            movedLeds = {ledsReg[0], ledsReg[NUM_LEDS-1:1]};
        end
`else
        // A worm already touching the leading end reverses on this step instead of advancing.
        if (!dirReg) begin
            if (ledsReg[NUM_LEDS-1]) begin
                movedDir  = 1'b1;
                movedLeds = ledsReg >> 1;
            end else begin
                movedLeds = ledsReg << 1;
            end
        end else begin
            if (ledsReg[0]) begin
                movedDir  = 1'b0;
                movedLeds = ledsReg << 1;
            end else begin
                movedLeds = ledsReg >> 1;
            end
        end
`endif
    end

    always_comb begin
        stateNext = stateReg;
        ledsNext  = ledsReg;
        countNext = countReg;
        tickNext  = 1'b0;
        dirNext   = dirReg;
        case (stateReg)
            IDLE: begin
                ledsNext = '0;
                if (start && !stop) begin
                    stateNext = RUN;
                    countNext = '0;
                    ledsNext  = dirIn ? HIGH_WORM : LOW_WORM;
                    dirNext   = dirIn;
                end
            end
            RUN: begin
                if (stop) begin
                    stateNext = PAUSE;
                end else if (countReg >= termCount) begin
                    countNext = '0;
                    tickNext  = 1'b1;
                    ledsNext  = movedLeds;
                    dirNext   = movedDir;
                end else begin
                    countNext = countReg + ONE_CNT;
                end
            end
            PAUSE: begin
                // stop outranks start, so a simultaneous pair returns to IDLE.
                if (stop) begin
                    stateNext = IDLE;
                    ledsNext  = '0;
                end else if (start) begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = IDLE;
                ledsNext  = '0;
            end
        endcase
    end

    always_ff @(posedge inClk) begin
        if (reset) begin
            stateReg <= IDLE;
            ledsReg  <= '0;
            countReg <= '0;
            tickReg  <= 1'b0;
            dirReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            ledsReg  <= ledsNext;
            countReg <= countNext;
            tickReg  <= tickNext;
            dirReg   <= dirNext;
        end
    end

    assign leds     = ledsReg;
    assign stepTick = tickReg;
    assign dirOut   = dirReg;
    assign busy     = (stateReg != IDLE);

endmodule

// File: tb/tb_led_worm_sequencer.sv
// Self-checking bench for led_worm_sequencer with BASE_DIV=8, NUM_LEDS=8, WORM_LEN=3.
// Expected worm positions are queued as stimulus is driven and compared on every stepTick.
module tb_led_worm_sequencer;

    typedef struct packed {
        logic [7:0] leds;
        logic       dir;
    } expT;

    logic       inClk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dirIn = 1'b0;
    logic [1:0] speedSel = 2'd0;
    logic [7:0] leds;
    logic       stepTick;
    logic       dirOut;
    logic       busy;

    int  checks = 0;
    int  errors = 0;
    expT sbq[$];

    always #5 inClk = ~inClk;

    led_worm_sequencer #(
        .NUM_LEDS(8),
        .WORM_LEN(3),
        .DIV_W(24),
        .BASE_DIV(8)
    ) dut (
        .inClk(inClk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .dirIn(dirIn),
        .speedSel(speedSel),
        .leds(leds),
        .stepTick(stepTick),
        .dirOut(dirOut),
        .busy(busy)
    );

    // Scoreboard monitor: each stepTick must match the next queued worm position.
    always @(posedge inClk) begin
        expT e;
        #2;
        if (stepTick === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected: got leds=%b dir=%b, no step was expected", leds, dirOut);
            end else begin
                e = sbq.pop_front();
                if (leds !== e.leds || dirOut !== e.dir) begin
                    errors++;
                    $display("FAIL tick_state: got leds=%b dir=%b, required leds=%b dir=%b",
                             leds, dirOut, e.leds, e.dir);
                end else begin
                    $display("tick: leds=%b dir=%b ok", leds, dirOut);
                end
            end
        end
    end

    task automatic step();
        @(posedge inClk);
        #1;
    endtask

    task automatic waitTick(output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            step();
            n++;
            if (stepTick === 1'b1) got = 1'b1;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (leds !== 8'h00 || stepTick !== 1'b0 || dirOut !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got leds=%b tick=%b dir=%b busy=%b, required all zero",
                     leds, stepTick, dirOut, busy);
        end else $display("reset_state: ok");
    endtask

    task automatic test_bounce();
        int n;
        bit got;
        doReset();
        speedSel = 2'd0;
        dirIn    = 1'b0;
        sbq.push_back('{8'b00001110, 1'b0});
        sbq.push_back('{8'b00011100, 1'b0});
        sbq.push_back('{8'b00111000, 1'b0});
        sbq.push_back('{8'b01110000, 1'b0});
        sbq.push_back('{8'b11100000, 1'b0});
`ifdef LED_WORM_WRAP_EN
        sbq.push_back('{8'b11000001, 1'b0});
`else
        sbq.push_back('{8'b01110000, 1'b1});
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (leds !== 8'b00000111 || busy !== 1'b1 || dirOut !== 1'b0) begin
            errors++;
            $display("FAIL load_low: got leds=%b busy=%b dir=%b, required 00000111 1 0", leds, busy, dirOut);
        end else $display("load_low: ok");
        for (int t = 1; t <= 6; t++) begin
            waitTick(n, got);
            checks++;
            if (!got || n != 8) begin
                errors++;
                $display("FAIL step_period%0d: got %0d cycles (seen=%0b), required 8", t, n, got);
            end else $display("step_period%0d: 8 cycles ok", t);
        end
        stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        checks++;
        if (leds !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_twice: got leds=%b busy=%b, required 00000000 0", leds, busy);
        end else $display("stop_twice: ok");
    endtask

    task automatic test_speed();
        int n;
        bit got;
        doReset();
        speedSel = 2'd3;
        dirIn    = 1'b0;
        sbq.push_back('{8'b00001110, 1'b0});
        sbq.push_back('{8'b00011100, 1'b0});
        sbq.push_back('{8'b00111000, 1'b0});
        sbq.push_back('{8'b01110000, 1'b0});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            waitTick(n, got);
            checks++;
            if (!got || n != 1) begin
                errors++;
                $display("FAIL fast_period%0d: got %0d cycles (seen=%0b), required 1", t, n, got);
            end else $display("fast_period%0d: 1 cycle ok", t);
        end
        speedSel = 2'd0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (stepTick !== 1'b0) begin
                errors++;
                $display("FAIL slow_quiet%0d: got stepTick=%b, required 0", c, stepTick);
            end
        end
        sbq.push_back('{8'b11100000, 1'b0});
        waitTick(n, got);
        checks++;
        if (!got || n != 3) begin
            errors++;
            $display("FAIL count5_sel0: got %0d cycles (seen=%0b), required 3", n, got);
        end else $display("count5_sel0: 3 cycles ok");
        for (int c = 0; c < 5; c++) step();
        speedSel = 2'd2;
`ifdef LED_WORM_WRAP_EN
        sbq.push_back('{8'b11000001, 1'b0});
`else
        sbq.push_back('{8'b01110000, 1'b1});
`endif
        waitTick(n, got);
        checks++;
        if (!got || n != 1) begin
            errors++;
            $display("FAIL count5_sel2: got %0d cycles (seen=%0b), required 1", n, got);
        end else $display("count5_sel2: 1 cycle ok");
        speedSel = 2'd0;
    endtask

    task automatic test_pause();
        int n;
        bit got;
        doReset();
        speedSel = 2'd0;
        dirIn    = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (leds !== 8'b11100000 || dirOut !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_high: got leds=%b dir=%b busy=%b, required 11100000 1 1", leds, dirOut, busy);
        end else $display("load_high: ok");
        for (int c = 0; c < 4; c++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pause_busy: got busy=%b, required 1", busy);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (stepTick !== 1'b0 || leds !== 8'b11100000) begin
                errors++;
                $display("FAIL pause_hold%0d: got tick=%b leds=%b, required 0 11100000", c, stepTick, leds);
            end
        end
        sbq.push_back('{8'b01110000, 1'b1});
        start = 1'b1;
        step();
        start = 1'b0;
        waitTick(n, got);
        checks++;
        if (!got || n != 4) begin
            errors++;
            $display("FAIL resume_period: got %0d cycles (seen=%0b), required 4", n, got);
        end else $display("resume_period: 4 cycles ok");
        stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        checks++;
        if (leds !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pause_to_idle: got leds=%b busy=%b, required 00000000 0", leds, busy);
        end else $display("pause_to_idle: ok");
    endtask

    task automatic test_priority();
        doReset();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || leds !== 8'h00) begin
            errors++;
            $display("FAIL start_stop_idle: got busy=%b leds=%b, required 0 00000000", busy, leds);
        end else $display("start_stop_idle: ok");
        dirIn = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 3; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (leds !== 8'h00 || stepTick !== 1'b0 || dirOut !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got leds=%b tick=%b dir=%b busy=%b, required all zero",
                     leds, stepTick, dirOut, busy);
        end else $display("reset_mid_run: ok");
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_speed();
        test_pause();
        test_priority();
        step();
        step();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending steps, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
